// File: rtl/pixel_framebuffer.sv
// pixel_framebuffer: stores a 160x120 grid of 3-bit pixels written through a
// plot port and scans it out as 640x480 VGA. Each stored pixel covers a 4x4
// block on screen. A one-cycle frame_tick marks the start of vertical blank.
module pixel_framebuffer #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int SCALE_SHIFT     = 2,
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       plot_dropped,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_pix_en,
    output logic       frame_tick
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST  = H_ACTIVE + H_FP;
    localparam int HS_LAST   = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST  = V_ACTIVE + V_FP;
    localparam int VS_LAST   = VS_FIRST + V_SYNC - 1;
    localparam int MEM_DEPTH = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int H_W       = $clog2(H_TOTAL);
    localparam int V_W       = $clog2(V_TOTAL);

    // Frame store; never reset, the game clears the screen itself.
    logic [2:0]        mem [MEM_DEPTH];

    logic              pix_en;
    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic              h_last;
    logic              v_last;

    logic              in_range_p0;
    logic              wr_ok_p0;
    logic [ADDR_W-1:0] wr_addr_p0;
    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [2:0]        wr_data_p1;

    logic              active_p0;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic [2:0]        rd_data_p1;

    assign vga_pix_en = pix_en;

    // Stage p0: decode the plot request into a row-major frame-store address.
    always_comb begin
        in_range_p0 = (int'(x) < X_SCREEN_PIXELS) && (int'(y) < Y_SCREEN_PIXELS);
        wr_ok_p0    = plot && in_range_p0;
        wr_addr_p0  = ADDR_W'(int'(y) * X_SCREEN_PIXELS + int'(x));
    end

    // Stage p0: scan position decode; the read address parks at 0 in blanking.
    always_comb begin
        h_last     = (int'(h_cnt) == H_TOTAL - 1);
        v_last     = (int'(v_cnt) == V_TOTAL - 1);
        active_p0  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        rd_addr_p0 = '0;
        if (active_p0) begin
            rd_addr_p0 = ADDR_W'((int'(v_cnt) >> SCALE_SHIFT) * X_SCREEN_PIXELS
                                 + (int'(h_cnt) >> SCALE_SHIFT));
        end
    end

    // Stage p1 write valid: held low through reset so a plot on a reset edge is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_vld_p1 <= 1'b0;
        end else begin
            wr_vld_p1 <= wr_ok_p0;
        end
    end

    // Stage p1 write payload and the frame-store write itself.
    always_ff @(posedge clk) begin
        wr_addr_p1 <= wr_addr_p0;
        wr_data_p1 <= colour;
        if (wr_vld_p1) begin
            mem[wr_addr_p1] <= wr_data_p1;
        end
    end

    // Stage p1 read on the non-tick edge. The forward makes a plot from the
    // previous cycle visible, so the delayed write looks like an immediate one;
    // a plot sampled on this same edge is not forwarded (read-before-write).
    always_ff @(posedge clk) begin
        if (!pix_en) begin
            if (wr_vld_p1 && (wr_addr_p1 == rd_addr_p0)) begin
                rd_data_p1 <= wr_data_p1;
            end else begin
                rd_data_p1 <= mem[rd_addr_p0];
            end
        end
    end

    // Pixel-tick divider and the 800x525 scan counters, advancing on ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_en <= !pix_en;
            if (pix_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    if (v_last) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p2: register the VGA outputs on each tick from the current position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            vga_blank_n <= active_p0;
            vga_hs      <= !((int'(h_cnt) >= HS_FIRST) && (int'(h_cnt) <= HS_LAST));
            vga_vs      <= !((int'(v_cnt) >= VS_FIRST) && (int'(v_cnt) <= VS_LAST));
            vga_r       <= active_p0 ? {8{rd_data_p1[2]}} : 8'h00;
            vga_g       <= active_p0 ? {8{rd_data_p1[1]}} : 8'h00;
            vga_b       <= active_p0 ? {8{rd_data_p1[0]}} : 8'h00;
        end
    end

    // Single-cycle status pulses: start of vertical blank and rejected plots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick   <= 1'b0;
            plot_dropped <= 1'b0;
        end else begin
            frame_tick   <= pix_en && h_last && (int'(v_cnt) == V_ACTIVE - 1);
            plot_dropped <= plot && !in_range_p0;
        end
    end

endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
Receiving end of the pixel-plot interface driven by the rocket, mothership and other game sprites. Each plot request (x, y, colour, plot) is written into an internal 160x120x3-bit frame memory. The block continuously scans that memory out as 640x480 VGA timing, with each stored pixel replicated into a 4x4 block. It also gives game logic a once-per-frame tick, which sprite FSMs use to pace redraws.

Parameters:
X_SCREEN_PIXELS, 160, stored pixels per row
Y_SCREEN_PIXELS, 120, stored rows
SCALE_SHIFT, 2, log2 of horizontal/vertical replication factor
H_ACTIVE, 640, visible pixel ticks per line
H_FP, 16, horizontal front porch ticks
H_SYNC, 96, hsync pulse ticks
H_BP, 48, horizontal back porch ticks
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch lines
V_SYNC, 2, vsync pulse lines
V_BP, 33, vertical back porch lines

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
x  in  8  plot column, 0..159
y  in  7  plot row, 0..119
colour  in  3  {R,G,B} plot colour
plot  in  1  write request, sampled on each clk edge
plot_dropped  out  1  one-cycle pulse when plot=1 and coordinates are out of range
vga_r  out  8  red channel
vga_g  out  8  green channel
vga_b  out  8  blue channel
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_blank_n  out  1  high during the active region
vga_pix_en  out  1  pixel-tick strobe, one clk in every two
frame_tick  out  1  one-cycle pulse at start of vertical blank

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - reset is asynchronous and active-high.
  - Reset values: pix_en=0, h_cnt=0, v_cnt=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_tick=0, plot_dropped=0.
  - Reset does not clear frame memory. Contents after power-up are undefined; game FSMs clear the screen explicitly.
  - Reset mid-frame: counters restart at (0,0) on release. Any write in flight on the reset edge is discarded.
- Write port (every clk):
  - If plot=1, x<160 and y<120: mem[addr] <= colour, where addr = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x.
  - One write per cycle, no backpressure. Back-to-back plots on consecutive cycles must all land.
  - If plot=1 and x>=160 or y>=120: no write, and plot_dropped=1 on the following cycle.
- Pixel tick:
  - pix_en toggles every clk; vga_pix_en = pix_en.
  - A "tick" is a clk edge on which pix_en=1.
- Counters:
  - h_cnt runs 0..799 and advances on ticks.
  - v_cnt runs 0..524 and advances when h_cnt wraps 799->0.
  - v_cnt wraps 524->0.
- Read pipeline:
  - On an edge with pix_en=0: rd_data <= mem[(v_cnt>>2)*160 + (h_cnt>>2)]. Read address is clamped to 0 outside the active region.
  - On the following tick edge, outputs register values derived from the current h_cnt/v_cnt, and the counters then advance.
  - Net result: outputs always reflect the counter pair that held during the preceding two clks.
- Output encoding:
  - active = h_cnt<640 && v_cnt<480.
  - vga_blank_n = active.
  - vga_hs = 0 when 656<=h_cnt<=751, otherwise 1.
  - vga_vs = 0 when 490<=v_cnt<=491, otherwise 1.
  - vga_r = {8{rd_data[2]}}, vga_g = {8{rd_data[1]}}, vga_b = {8{rd_data[0]}} when active; all 0 when inactive.
- Read/write collision on the same address in the same cycle: the read returns old data (read-before-write). The new value is visible from the next read onward.
- frame_tick: one clk pulse on the tick edge where v_cnt goes 479->480 (h_cnt 799->0).

Test Plan:
- Reset: hold reset 3 clks, then release. Required: vga_hs=1, vga_vs=1, blank_n=0, rgb=0 during reset. First hsync low occurs after 656 ticks (1312 clks) from release.
- Timing: run 2 frames. Required per line: exactly 96 low ticks of hs and 640 blank_n ticks. Per frame: 800*525 ticks and exactly 2 vs-low lines. frame_tick fires once per 840000 clks.
- Single plot: plot (x=73, y=105, colour=3'b101). Required in the next frame: at v_cnt 420..423 and h_cnt 292..295, vga_r=8'hFF, vga_g=8'h00, vga_b=8'hFF. The neighbouring stored pixel keeps its prior value.
- Burst plot: 110 consecutive plots filling an 11x10 block starting at (147,110), including corners (157,119) and (0,0) plotted separately. Required: scanout shows every pixel, and no plot_dropped.
- Out of range: plot (x=160, y=5) then (x=3, y=120). Required: plot_dropped pulses twice, each 1 clk late, and memory is unchanged.
- Collision and reset mid-frame: write address A while it is being read. Required: old colour is shown that frame and the new colour the next frame. Then assert reset at v_cnt=200. Required: outputs return to reset values immediately and counters restart at (0,0) after release.
